// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encodings and default sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    NEXT = 2'd2
  } state_t;

  localparam logic [15:0] DEFAULT_TIMEOUT = 16'd50000;
  localparam int unsigned DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after last_g+1, with wrap-around.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_g,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx
);

  logic [IDX_W-1:0] start;
  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] off;
  logic             found;

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return (v >= NREQ) ? IDX_W'(v - NREQ) : IDX_W'(v);
  endfunction

  // Rotate so the search starts just after the previous winner, then map back.
  always_comb begin
    start    = (last_g >= IDX_W'(NREQ - 1)) ? '0 : last_g + IDX_W'(1);
    rot      = '0;
    found    = 1'b0;
    off      = '0;
    pick     = '0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rot[k] = req[wrap_idx(k + 32'(start))];
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
    if (found) begin
      pick_idx       = wrap_idx(32'(off) + 32'(start));
      pick[pick_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter between NREQ byte streams,
// with a per-byte inactivity watchdog that aborts stalled packets.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter logic [15:0] TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ack,
  output logic [NREQ-1:0]     grant,
  input  logic                tx_ready,
  input  logic                tx_accept,
  output logic                tx_start,
  output logic [7:0]          tx_byte,
  output logic                busy,
  output logic [CNT_W-1:0]    abort_cnt
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WD_W  = 16;

  state_t           state;
  logic [IDX_W-1:0] g_idx;
  logic [IDX_W-1:0] last_g;
  logic             last_q;
  logic [WD_W-1:0]  wdog;
  logic [NREQ-1:0]  pick;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req     (req),
    .last_g  (last_g),
    .pick    (pick),
    .pick_idx(pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      req_ack   <= '0;
      tx_start  <= 1'b0;
      tx_byte   <= '0;
      busy      <= 1'b0;
      abort_cnt <= '0;
      last_g    <= IDX_W'(NREQ - 1);
      g_idx     <= '0;
      last_q    <= 1'b0;
      wdog      <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (tx_ready && (|req)) begin
            grant    <= pick;
            g_idx    <= pick_idx;
            tx_byte  <= req_data[8*pick_idx +: 8];
            last_q   <= req_last[pick_idx];
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          // Byte and last flag were registered at load; requester inputs are ignored here.
          if (tx_accept) begin
            tx_start <= 1'b0;
            req_ack  <= grant;
            wdog     <= '0;
            if (last_q) begin
              grant  <= '0;
              last_g <= g_idx;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          // Waiting on tx_ready with a byte present never counts toward the watchdog.
          if (req[g_idx]) begin
            if (tx_ready) begin
              tx_byte  <= req_data[8*g_idx +: 8];
              last_q   <= req_last[g_idx];
              tx_start <= 1'b1;
              state    <= SEND;
            end
          end else if (wdog == TIMEOUT - 16'd1) begin
            grant  <= '0;
            last_g <= g_idx;
            busy   <= 1'b0;
            state  <= IDLE;
            if (abort_cnt != '1) begin
              abort_cnt <= abort_cnt + CNT_W'(1);
            end
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          tx_start <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a UART model, and a byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ = 3;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;
  typedef logic [8:0] ent_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [8*NREQ-1:0]   req_data = '0;
  logic [NREQ-1:0]     req_last = '0;
  logic [NREQ-1:0]     req_ack;
  logic [NREQ-1:0]     grant;
  wire                 tx_ready;
  logic                tx_accept = 1'b0;
  logic                tx_start;
  logic [7:0]          tx_byte;
  logic                busy;
  logic [7:0]          abort_cnt;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  ent_t        rq[NREQ][$];
  int          ack_cnt[NREQ] = '{default: 0};
  int          u_cnt = 0;
  logic        force_low = 1'b0;
  logic        ack_due = 1'b0;
  logic [NREQ-1:0] exp_ack = '0;
  logic        start_q = 1'b0;
  logic        ready_at_edge = 1'b0;

  assign tx_ready = (u_cnt == 0) && !force_low;

  uart_tx_arbiter #(
    .NREQ   (NREQ),
    .TIMEOUT(16'd20),
    .CNT_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .grant    (grant),
    .tx_ready (tx_ready),
    .tx_accept(tx_accept),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .busy     (busy),
    .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ready_at_edge <= tx_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input logic l);
    rq[i].push_back({l, d});
    exp_q.push_back('{idx: i, data: d});
  endtask

  // Requesters: present the queue head, retire it on req_ack.
  always @(negedge clk) begin : req_model
    ent_t f;
    for (int i = 0; i < NREQ; i++) begin
      if (!rst && req_ack[i]) begin
        ack_cnt[i]++;
        if (rq[i].size() > 0) void'(rq[i].pop_front());
      end
      if (rq[i].size() > 0) begin
        f                  = rq[i][0];
        req[i]             = 1'b1;
        req_data[8*i +: 8] = f[7:0];
        req_last[i]        = f[8];
      end else begin
        req[i]             = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  // UART: accept one cycle after tx_start, then stay not-ready for 10 cycles.
  always @(negedge clk) begin : uart_model
    exp_t e;
    logic [NREQ-1:0] oh;
    if (rst) begin
      tx_accept = 1'b0;
      u_cnt     = 0;
      ack_due   = 1'b0;
    end else begin
      if (ack_due) begin
        chk("req_ack", 32'(req_ack), 32'(exp_ack));
        ack_due = 1'b0;
      end else if (req_ack !== '0) begin
        chk("spurious_ack", 32'(req_ack), 32'h0);
      end
      if (tx_start && !start_q) chk("start_needs_ready", 32'(ready_at_edge), 32'h1);
      chk("grant_onehot0", 32'($onehot0(grant)), 32'h1);
      chk("busy_vs_grant", 32'(busy), 32'(|grant));
      if (tx_accept) begin
        tx_accept = 1'b0;
        u_cnt     = 10;
      end else if (u_cnt > 0) begin
        u_cnt--;
      end else if (tx_start && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(exp_q.size()), 32'h1);
          exp_ack = grant;
        end else begin
          e  = exp_q.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk("tx_byte", 32'(tx_byte), 32'(e.data));
          chk("grant", 32'(grant), 32'(oh));
          exp_ack = oh;
        end
        tx_accept = 1'b1;
        ack_due   = 1'b1;
      end
    end
    start_q = tx_start;
  end

  task automatic flush();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_req_ack"}, 32'(req_ack), 32'h0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'h0);
    chk({tag, "_tx_byte"}, 32'(tx_byte), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_abort_cnt"}, 32'(abort_cnt), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    logic [1:0] st;
    while ((exp_q.size() != 0 || ack_due || busy !== 1'b0 || tx_start !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    st = {exp_q.size() == 0, busy};
    chk({tag, "_drained"}, 32'(st), 32'h2);
  endtask

  task automatic wait_ack(input int i, input int budget, input string tag);
    int n = 0;
    while (req_ack[i] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_ack_seen"}, 32'(req_ack[i]), 32'h1);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n = 0;
    while (tx_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_start_seen"}, 32'(tx_start), 32'h1);
  endtask

  initial begin : hard_limit
    #500000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench did not complete");
  end

  initial begin : stim
    int base;
    int n;

    repeat (3) tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Single "OK\r\n" packet from the parser.
    base = ack_cnt[0];
    push_byte(0, 8'h4F, 1'b0);
    push_byte(0, 8'h4B, 1'b0);
    push_byte(0, 8'h0D, 1'b0);
    push_byte(0, 8'h0A, 1'b1);
    tick();
    chk("first_start_latency", 32'(tx_start), 32'h1);
    chk("first_byte", 32'(tx_byte), 32'h4F);
    chk("first_grant", 32'(grant), 32'h1);
    wait_drain(200, "single");
    chk("single_acks", 32'(ack_cnt[0] - base), 32'h4);
    chk("single_idle_grant", 32'(grant), 32'h0);

    // Round-robin across three always-ready requesters, two packets each.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        push_byte(i, 8'(8'h10 * i + 2 * p), 1'b0);
        push_byte(i, 8'(8'h10 * i + 2 * p + 1), 1'b1);
      end
    end
    wait_drain(400, "rr");

    // req1 arrives mid-packet and must wait for all five req0 bytes.
    base = ack_cnt[0];
    for (int k = 0; k < 5; k++) push_byte(0, 8'(8'h50 + k), k == 4);
    wait_ack(0, 50, "preempt_first");
    wait_start(50, "preempt_second");
    push_byte(1, 8'h60, 1'b0);
    push_byte(1, 8'h61, 1'b1);
    wait_drain(300, "preempt");
    chk("preempt_req0_acks", 32'(ack_cnt[0] - base), 32'h5);

    // Stalled req2 is aborted after TIMEOUT cycles; pending req0 goes next.
    push_byte(2, 8'hA5, 1'b0);
    push_byte(0, 8'h70, 1'b0);
    push_byte(0, 8'h71, 1'b1);
    wait_ack(2, 50, "wdog");
    n = 0;
    while (grant === 3'b100 && n < 100) begin
      tick();
      n++;
    end
    chk("wdog_cycles", 32'(n), 32'd20);
    chk("wdog_abort_cnt", 32'(abort_cnt), 32'h1);
    chk("wdog_grant_clear", 32'(grant), 32'h0);
    wait_drain(200, "wdog");

    // Saturation of the abort counter.
    for (int k = 0; k < 254; k++) begin
      push_byte(2, 8'(k), 1'b0);
      wait_drain(100, "abort");
    end
    chk("abort_cnt_255", 32'(abort_cnt), 32'd255);
    for (int k = 0; k < 45; k++) begin
      push_byte(2, 8'(k), 1'b0);
      wait_drain(100, "abort_sat");
    end
    chk("abort_cnt_sat", 32'(abort_cnt), 32'd255);

    // Reset while a byte is in SEND.
    push_byte(0, 8'h80, 1'b0);
    push_byte(0, 8'h81, 1'b0);
    push_byte(0, 8'h82, 1'b1);
    wait_start(50, "midreset");
    do_reset();
    chk_reset_outputs("midreset");
    push_byte(0, 8'hA0, 1'b0);
    push_byte(0, 8'hA1, 1'b1);
    push_byte(1, 8'h90, 1'b0);
    push_byte(1, 8'h91, 1'b1);
    wait_drain(200, "post_reset");

    // tx_ready held low: no start, no abort, start one cycle after release.
    force_low = 1'b1;
    push_byte(1, 8'hB0, 1'b0);
    push_byte(1, 8'hB1, 1'b1);
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("gated_no_start", 32'(tx_start), 32'h0);
    end
    chk("gated_no_abort", 32'(abort_cnt), 32'h0);
    force_low = 1'b0;
    tick();
    chk("ready_release_latency", 32'(tx_start), 32'h1);
    wait_ack(1, 50, "gated_first");
    force_low = 1'b1;
    repeat (60) tick();
    chk("gated_next_grant", 32'(grant), 32'h2);
    chk("gated_next_busy", 32'(busy), 32'h1);
    chk("gated_next_no_abort", 32'(abort_cnt), 32'h0);
    force_low = 1'b0;
    wait_drain(200, "gated");
    chk("gated_final_abort", 32'(abort_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
